shift_left_logical_seq: RTL and testbench



---
 rtl/shift_left_logical_seq.sv | 107 ++++++++++
 tb/tb_shift_left_logical_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_logical_seq.sv
// Sequential logical-left shifter (RV32 SLL/SLLI) with valid/ready on both sides.
// The shift runs as five binary stages (16, 8, 4, 2, 1), one per clock, on a
// registered working value.
// Optional build macro: SLL_EARLY_EXIT_EN. When defined, the shifter skips the
// trailing stages whose shift-amount bits are all zero. Results are the same;
// only latency changes.
module shift_left_logical_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] ShAm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Out
);

  localparam int unsigned CNT_W = $clog2(SHAMT_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [SHAMT_W-1:0] shamt, shamt_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   stage_idx;
  logic [SHAMT_W-1:0] stage_dist;
`ifdef SLL_EARLY_EXIT_EN
  logic [SHAMT_W-1:0] low_mask;
`endif

  // Next-state, next working value and stage bookkeeping.
  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    shamt_nxt  = shamt;
    cnt_nxt    = cnt;
    // Stage k handles shift-amount bit (SHAMT_W-1-k), i.e. distance 2^(SHAMT_W-1-k).
    stage_idx  = LAST_STAGE - cnt;
    stage_dist = SHAMT_W'(1) << stage_idx;
`ifdef SLL_EARLY_EXIT_EN
    // Amount bits below the current stage; all zero means no stage is left to do.
    low_mask   = stage_dist - SHAMT_W'(1);
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nxt  = In;
          shamt_nxt = ShAm;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
`ifdef SLL_EARLY_EXIT_EN
          if (ShAm == '0) state_nxt = DONE;
`endif
        end
      end
      SHIFT: begin
        if (shamt[stage_idx[CNT_W-2:0]]) work_nxt = work << stage_dist;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST_STAGE) begin
          state_nxt = DONE;
        end
`ifdef SLL_EARLY_EXIT_EN
        else if ((shamt & low_mask) == '0) begin
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      shamt     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      shamt     <= shamt_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // The result port is the working register itself.
  assign Out = work;

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Directed bench for shift_left_logical_seq; honours SLL_EARLY_EXIT_EN for latency.
module tb_shift_left_logical_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] In;
  logic [4:0]  ShAm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;

  int checks;
  int errors;

`ifdef SLL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  shift_left_logical_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (In),
    .ShAm      (ShAm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Edges from the accepting edge (inclusive) to out_valid.
  function automatic int exp_lat(input logic [4:0] sh);
    int early;
    early = 1;
    for (int p = 4; p >= 0; p--) begin
      if (sh[p]) early = 6 - p;
    end
    return EARLY ? early : 6;
  endfunction

  // Present one request while the DUT is idle; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] d, input logic [4:0] s);
    @(negedge clk);
    In = d;
    ShAm = s;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts further edges until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    In = 32'hDEAD_BEEF;
    ShAm = 5'd7;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (Out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 00000000", Out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    send(32'h0000_0001, 5'd5);
    wait_valid(n);
    checks++; if (n + 1 != exp_lat(5'd5)) begin errors++; $display("FAIL basic_latency got %0d want %0d", n + 1, exp_lat(5'd5)); end
    checks++; if (Out !== 32'h0000_0020) begin errors++; $display("FAIL basic_out got %h want 00000020", Out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %0b want 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_after got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after got %0b want 1", in_ready); end
  endtask

  task automatic test_patterns;
    logic [31:0] din [7];
    logic [4:0]  sh  [7];
    logic [31:0] exp [7];
    int n;
    din = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hA5A5_A5A5,
            32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF};
    sh  = '{5'd31, 5'd0, 5'd16, 5'd1, 5'd31, 5'd12, 5'd8};
    exp = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h4B4B_4B4A,
            32'h8000_0000, 32'h4567_8000, 32'hADBE_EF00};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(din[i], sh[i]);
      wait_valid(n);
      checks++; if (n + 1 != exp_lat(sh[i])) begin errors++; $display("FAIL pattern%0d_latency got %0d want %0d", i, n + 1, exp_lat(sh[i])); end
      checks++; if (Out !== exp[i]) begin errors++; $display("FAIL pattern%0d_out got %h want %h", i, Out, exp[i]); end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    send(32'h1234_5678, 5'd4);
    wait_valid(n);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_seen got %0b want 1", out_valid); end
    checks++; if (Out !== 32'h2345_6780) begin errors++; $display("FAIL bp_out got %h want 23456780", Out); end
    // Stall for 10 cycles with a competing request offered; it must not be taken.
    for (int c = 0; c < 10; c++) begin
      In = 32'hFFFF_FFFF;
      ShAm = 5'd1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d got %0b want 1", c, out_valid); end
      checks++; if (Out !== 32'h2345_6780) begin errors++; $display("FAIL bp_hold_out c%0d got %h want 23456780", c, Out); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready c%0d got %0b want 0", c, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer c%0d got %0b want 0", c, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_in_ready c%0d got %0b want 1", c, in_ready); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    out_ready = 1'b1;
    send(32'h0000_00AB, 5'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (Out !== 32'h0) begin errors++; $display("FAIL rstmid_out got %h want 00000000", Out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_result got %0b want 0", out_valid); end
    send(32'h0000_00FF, 5'd8);
    wait_valid(n);
    checks++; if (n + 1 != exp_lat(5'd8)) begin errors++; $display("FAIL rstmid_next_latency got %0d want %0d", n + 1, exp_lat(5'd8)); end
    checks++; if (Out !== 32'h0000_FF00) begin errors++; $display("FAIL rstmid_next_out got %h want 0000ff00", Out); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_changing_inputs;
    int n;
    out_ready = 1'b0;
    send(32'h0000_0003, 5'd3);
    n = 0;
    while (!out_valid && n < 40) begin
      In = $urandom;
      ShAm = 5'($urandom_range(0, 31));
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++; if (n + 1 != exp_lat(5'd3)) begin errors++; $display("FAIL chg_latency got %0d want %0d", n + 1, exp_lat(5'd3)); end
    checks++; if (Out !== 32'h0000_0018) begin errors++; $display("FAIL chg_out got %h want 00000018", Out); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chg_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int n;
    int m;
    out_ready = 1'b1;
    @(negedge clk);
    In = 32'h8000_0001;
    ShAm = 5'd1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    In = 32'h0F0F_0F0F;
    ShAm = 5'd3;
    wait_valid(n);
    checks++; if (Out !== 32'h0000_0002) begin errors++; $display("FAIL b2b_first_out got %h want 00000002", Out); end
    @(posedge clk);
    @(negedge clk);
    wait_valid(m);
    m = m + 1;
    in_valid = 1'b0;
    checks++; if (Out !== 32'h7878_7878) begin errors++; $display("FAIL b2b_second_out got %h want 78787878", Out); end
    checks++; if (m != exp_lat(5'd3) + 1) begin errors++; $display("FAIL b2b_period got %0d want %0d", m, exp_lat(5'd3) + 1); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_changing_inputs();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
